// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI-lite slave with 8 word registers; define AXI_REGFILE_WRCNT_EN for the reg 6 write counter
module axi_lite_regfile #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    ADDR_WIDTH = 8,
   parameter logic [DATA_WIDTH-1:0] ID_VALUE   = 32'hA5A5_0001
) (
   input  logic                    s0_axi_aclk,
   input  logic                    s0_axi_areset,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
   input  logic                    s0_axi_awvalid,
   output logic                    s0_axi_awready,
   input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
   input  logic [DATA_WIDTH/8:0]   s0_axi_wstrb,
   input  logic                    s0_axi_wvalid,
   output logic                    s0_axi_wready,
   output logic                    s0_axi_bresp,
   output logic                    s0_axi_bvalid,
   input  logic                    s0_axi_bready,
   input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
   input  logic                    s0_axi_arvalid,
   output logic                    s0_axi_arready,
   output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
   output logic                    s0_axi_rresp,
   output logic                    s0_axi_rvalid,
   input  logic                    s0_axi_rready
);

   localparam int NB = DATA_WIDTH / 8;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   wstate_t                w_state, w_next;
   rstate_t                r_state, r_next;
   logic                   ready_en;
   logic                   aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0]  aw_addr_q, c_addr;
   logic [DATA_WIDTH-1:0]  w_data_q, c_data;
   logic [NB-1:0]          w_strb_q, c_strb;
   logic [2:0]             c_idx;
   logic                   c_err;
   logic                   bresp_q, rresp_q;
   logic [DATA_WIDTH-1:0]  rdata_q, rd_val, reg6_val;
   logic [DATA_WIDTH-1:0]  regs [0:5];
   logic                   unused_strb_msb;

   function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
      return (a[1:0] != 2'b00) || (a[ADDR_WIDTH-1:5] != '0);
   endfunction

   assign unused_strb_msb = s0_axi_wstrb[NB];

   // Holds all readies low during reset and releases them on the first edge after it.
   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset) ready_en <= 1'b0;
      else               ready_en <= 1'b1;
   end

   assign s0_axi_awready = ready_en && (w_state == W_IDLE || w_state == W_HAVE_DATA);
   assign s0_axi_wready  = ready_en && (w_state == W_IDLE || w_state == W_HAVE_ADDR);
   assign s0_axi_bvalid  = (w_state == W_RESP);
   assign s0_axi_bresp   = bresp_q;
   assign aw_hs          = s0_axi_awvalid && s0_axi_awready;
   assign w_hs           = s0_axi_wvalid && s0_axi_wready;

   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset) w_state <= W_IDLE;
      else               w_state <= w_next;
   end

   always_comb begin
      w_next = w_state;
      commit = 1'b0;
      case (w_state)
         W_IDLE: begin
            if (aw_hs && w_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end else if (aw_hs) begin
               w_next = W_HAVE_ADDR;
            end else if (w_hs) begin
               w_next = W_HAVE_DATA;
            end
         end
         W_HAVE_ADDR: begin
            if (w_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end
         end
         W_HAVE_DATA: begin
            if (aw_hs) begin
               w_next = W_RESP;
               commit = 1'b1;
            end
         end
         W_RESP: begin
            if (s0_axi_bready) w_next = W_IDLE;
         end
         default: w_next = W_IDLE;
      endcase
   end

   // The half of the transaction arriving on the commit edge comes straight from the bus.
   assign c_addr = (w_state == W_HAVE_ADDR) ? aw_addr_q : s0_axi_awaddr;
   assign c_data = (w_state == W_HAVE_DATA) ? w_data_q : s0_axi_wdata;
   assign c_strb = (w_state == W_HAVE_DATA) ? w_strb_q : s0_axi_wstrb[NB-1:0];
   assign c_idx  = c_addr[4:2];
   assign c_err  = addr_bad(c_addr) || (c_idx >= 3'd6);

   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset) begin
         aw_addr_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bresp_q   <= 1'b0;
         for (int i = 0; i < 6; i++) regs[i] <= '0;
      end else begin
         if (aw_hs) aw_addr_q <= s0_axi_awaddr;
         if (w_hs) begin
            w_data_q <= s0_axi_wdata;
            w_strb_q <= s0_axi_wstrb[NB-1:0];
         end
         if (commit) begin
            bresp_q <= c_err;
            if (!c_err) begin
               for (int b = 0; b < NB; b++) begin
                  if (c_strb[b]) regs[c_idx][8*b +: 8] <= c_data[8*b +: 8];
               end
            end
         end
      end
   end

`ifdef AXI_REGFILE_WRCNT_EN
   logic [DATA_WIDTH-1:0] wr_count;

   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset)        wr_count <= '0;
      else if (commit && !c_err) wr_count <= wr_count + DATA_WIDTH'(1);
   end

   assign reg6_val = wr_count;
`else
   assign reg6_val = '0;
`endif

   assign s0_axi_arready = ready_en && (r_state == R_IDLE);
   assign s0_axi_rvalid  = (r_state == R_DATA);
   assign s0_axi_rdata   = rdata_q;
   assign s0_axi_rresp   = rresp_q;
   assign ar_hs          = s0_axi_arvalid && s0_axi_arready;

   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset) r_state <= R_IDLE;
      else               r_state <= r_next;
   end

   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (ar_hs) r_next = R_DATA;
         R_DATA:  if (s0_axi_rready) r_next = R_IDLE;
         default: r_next = R_IDLE;
      endcase
   end

   always_comb begin
      rd_val = '0;
      case (s0_axi_araddr[4:2])
         3'd0:    rd_val = regs[0];
         3'd1:    rd_val = regs[1];
         3'd2:    rd_val = regs[2];
         3'd3:    rd_val = regs[3];
         3'd4:    rd_val = regs[4];
         3'd5:    rd_val = regs[5];
         3'd6:    rd_val = reg6_val;
         default: rd_val = ID_VALUE;
      endcase
   end

   always_ff @(posedge s0_axi_aclk or posedge s0_axi_areset) begin
      if (s0_axi_areset) begin
         rdata_q <= '0;
         rresp_q <= 1'b0;
      end else if (ar_hs) begin
         rresp_q <= addr_bad(s0_axi_araddr);
         rdata_q <= addr_bad(s0_axi_araddr) ? '0 : rd_val;
      end
   end

endmodule
